// File: rtl/soc_tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one fixed-latency TCDM slave port between NR_MASTERS requesters.
// Optional: define SOC_TCDM_ARB_DBG_PRIO_EN to give master 0 (debug) strict priority.
module soc_tcdm_rr_arbiter #(
    parameter int NR_MASTERS  = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SLV_LATENCY = 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NR_MASTERS-1:0]                   mst_req_i,
    input  logic [NR_MASTERS-1:0][ADDR_WIDTH-1:0]   mst_add_i,
    input  logic [NR_MASTERS-1:0]                   mst_wen_i,
    input  logic [NR_MASTERS-1:0][DATA_WIDTH-1:0]   mst_wdata_i,
    input  logic [NR_MASTERS-1:0][DATA_WIDTH/8-1:0] mst_be_i,
    output logic [NR_MASTERS-1:0]                   mst_gnt_o,
    output logic [NR_MASTERS-1:0]                   mst_r_valid_o,
    output logic [NR_MASTERS-1:0][DATA_WIDTH-1:0]   mst_r_rdata_o,
    output logic                                    slv_req_o,
    output logic [ADDR_WIDTH-1:0]                   slv_add_o,
    output logic                                    slv_wen_o,
    output logic [DATA_WIDTH-1:0]                   slv_wdata_o,
    output logic [DATA_WIDTH/8-1:0]                 slv_be_o,
    input  logic                                    slv_gnt_i,
    input  logic [DATA_WIDTH-1:0]                   slv_r_rdata_i
);

    localparam int IDX_W = $clog2(NR_MASTERS);

    logic [IDX_W-1:0]                   ptr_q, ptr_d;
    logic [IDX_W-1:0]                   winner;
    logic [IDX_W:0]                     cand;
    logic                               found;
    logic                               handshake;
    logic [SLV_LATENCY-1:0]             valid_q, valid_d;
    logic [SLV_LATENCY-1:0][IDX_W-1:0]  id_q, id_d;

    // First requesting index at or after ptr, wrapping at NR_MASTERS.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
`ifdef SOC_TCDM_ARB_DBG_PRIO_EN
        if (mst_req_i[0]) begin
            winner = '0;
            found  = 1'b1;
        end
`endif
        for (int i = 0; i < NR_MASTERS; i++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NR_MASTERS)) begin
                cand = cand - (IDX_W+1)'(NR_MASTERS);
            end
            if (!found && mst_req_i[cand[IDX_W-1:0]]) begin
                winner = cand[IDX_W-1:0];
                found  = 1'b1;
            end
        end
    end

    assign slv_req_o   = |mst_req_i;
    assign slv_add_o   = mst_add_i[winner];
    assign slv_wen_o   = mst_wen_i[winner];
    assign slv_wdata_o = mst_wdata_i[winner];
    assign slv_be_o    = mst_be_i[winner];
    assign handshake   = slv_req_o & slv_gnt_i;

    always_comb begin
        mst_gnt_o = '0;
        if (handshake) begin
            mst_gnt_o[winner] = 1'b1;
        end
    end

    // A debug-port handshake leaves the round-robin position untouched.
    always_comb begin
        ptr_d = ptr_q;
`ifdef SOC_TCDM_ARB_DBG_PRIO_EN
        if (handshake && !mst_req_i[0]) begin
`else
        if (handshake) begin
`endif
            if (winner == IDX_W'(NR_MASTERS-1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = winner + IDX_W'(1);
            end
        end
    end

    always_comb begin
        valid_d    = '0;
        id_d       = '0;
        valid_d[0] = handshake;
        id_d[0]    = winner;
        for (int i = 1; i < SLV_LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            id_d[i]    = id_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q   <= '0;
            valid_q <= '0;
            id_q    <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        mst_r_valid_o = '0;
        if (valid_q[SLV_LATENCY-1]) begin
            mst_r_valid_o[id_q[SLV_LATENCY-1]] = 1'b1;
        end
    end

    assign mst_r_rdata_o = {NR_MASTERS{slv_r_rdata_i}};

endmodule

// File: tb/tb_soc_tcdm_rr_arbiter.sv
// Directed bench for soc_tcdm_rr_arbiter: one instance with SLV_LATENCY=1 and one with 2, driven in lockstep.
module tb_soc_tcdm_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

`ifdef SOC_TCDM_ARB_DBG_PRIO_EN
    localparam logic [3:0] EXP_GNT_ALL [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    localparam logic [3:0] EXP_RV1_ALL [7] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    localparam logic [3:0] EXP_RV2_ALL [7] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    localparam logic [3:0] EXP_GNT_ALL [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    localparam logic [3:0] EXP_RV1_ALL [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
    localparam logic [3:0] EXP_RV2_ALL [7] = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif

    logic                      clk;
    logic                      rst;
    logic [N-1:0]              mst_req;
    logic [N-1:0][AW-1:0]      mst_add;
    logic [N-1:0]              mst_wen;
    logic [N-1:0][DW-1:0]      mst_wdata;
    logic [N-1:0][DW/8-1:0]    mst_be;
    logic                      slv_gnt;
    logic [DW-1:0]             slv_rdata;

    logic [N-1:0]              gnt1, gnt2, rv1, rv2;
    logic [N-1:0][DW-1:0]      rdata1, rdata2;
    logic                      sreq1, sreq2, swen1, swen2;
    logic [AW-1:0]             sadd1, sadd2;
    logic [DW-1:0]             swdata1, swdata2;
    logic [DW/8-1:0]           sbe1, sbe2;

    int check_count = 0;
    int pass_count  = 0;

    soc_tcdm_rr_arbiter #(.NR_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLV_LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .mst_req_i(mst_req), .mst_add_i(mst_add), .mst_wen_i(mst_wen),
        .mst_wdata_i(mst_wdata), .mst_be_i(mst_be),
        .mst_gnt_o(gnt1), .mst_r_valid_o(rv1), .mst_r_rdata_o(rdata1),
        .slv_req_o(sreq1), .slv_add_o(sadd1), .slv_wen_o(swen1),
        .slv_wdata_o(swdata1), .slv_be_o(sbe1),
        .slv_gnt_i(slv_gnt), .slv_r_rdata_i(slv_rdata)
    );

    soc_tcdm_rr_arbiter #(.NR_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLV_LATENCY(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst),
        .mst_req_i(mst_req), .mst_add_i(mst_add), .mst_wen_i(mst_wen),
        .mst_wdata_i(mst_wdata), .mst_be_i(mst_be),
        .mst_gnt_o(gnt2), .mst_r_valid_o(rv2), .mst_r_rdata_o(rdata2),
        .slv_req_o(sreq2), .slv_add_o(sadd2), .slv_wen_o(swen2),
        .slv_wdata_o(swdata2), .slv_be_o(sbe2),
        .slv_gnt_i(slv_gnt), .slv_r_rdata_i(slv_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs just after the rising edge, then move to the falling edge for sampling.
    task automatic applyStimulus(input logic r, input logic [N-1:0] req, input logic g, input logic [DW-1:0] rd);
        @(posedge clk);
        #1;
        rst       = r;
        mst_req   = req;
        slv_gnt   = g;
        slv_rdata = rd;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic checkCycle(input string tag, input logic [N-1:0] g, input logic [N-1:0] v1, input logic [N-1:0] v2);
        checkOutput({tag, " gnt1"}, 64'(gnt1), 64'(g));
        checkOutput({tag, " gnt2"}, 64'(gnt2), 64'(g));
        checkOutput({tag, " rvalid1"}, 64'(rv1), 64'(v1));
        checkOutput({tag, " rvalid2"}, 64'(rv2), 64'(v2));
    endtask

    initial begin
        rst       = 1'b1;
        mst_req   = '0;
        slv_gnt   = 1'b0;
        slv_rdata = '0;
        mst_wen   = '1;
        for (int i = 0; i < N; i++) begin
            mst_add[i]   = 32'h1000_0000 + 32'(i * 16);
            mst_wdata[i] = 32'hA000_0000 + 32'(i);
            mst_be[i]    = 4'hF;
        end

        applyStimulus(1'b1, 4'b0000, 1'b1, '0);
        applyStimulus(1'b1, 4'b0000, 1'b1, '0);
        checkCycle("reset", 4'b0000, 4'b0000, 4'b0000);
        checkOutput("reset slv_req", 64'(sreq1), 64'd0);

        for (int c = 0; c < 7; c++) begin
            applyStimulus(1'b0, (c < 5) ? 4'b1111 : 4'b0000, 1'b1, '0);
            checkCycle($sformatf("allreq c%0d", c), (c < 5) ? EXP_GNT_ALL[c] : 4'b0000,
                       EXP_RV1_ALL[c], EXP_RV2_ALL[c]);
        end
        applyStimulus(1'b0, 4'b0000, 1'b1, '0);
        checkCycle("idle", 4'b0000, 4'b0000, 4'b0000);

        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 4'b1010, 1'b0, '0);
            checkCycle($sformatf("stall c%0d", c), 4'b0000, 4'b0000, 4'b0000);
            checkOutput("stall slv_req", 64'(sreq1), 64'd1);
            checkOutput("stall slv_add", 64'(sadd1), 64'h1000_0010);
        end
        applyStimulus(1'b0, 4'b1010, 1'b1, '0);
        checkCycle("unstall m1", 4'b0010, 4'b0000, 4'b0000);
        applyStimulus(1'b0, 4'b1000, 1'b1, '0);
        checkCycle("unstall m3", 4'b1000, 4'b0010, 4'b0000);
        applyStimulus(1'b0, 4'b0000, 1'b1, '0);
        checkCycle("unstall drain1", 4'b0000, 4'b1000, 4'b0010);
        applyStimulus(1'b0, 4'b0000, 1'b1, '0);
        checkCycle("unstall drain2", 4'b0000, 4'b0000, 4'b1000);

        mst_add[2] = 32'h1C00_0040;
        mst_wen[2] = 1'b1;
        applyStimulus(1'b0, 4'b0100, 1'b1, '0);
        checkCycle("read m2", 4'b0100, 4'b0000, 4'b0000);
        checkOutput("read slv_add", 64'(sadd1), 64'h1C00_0040);
        checkOutput("read slv_wen", 64'(swen1), 64'd1);
        mst_wen[1]   = 1'b0;
        mst_wdata[1] = 32'h1234_5678;
        mst_be[1]    = 4'b0011;
        applyStimulus(1'b0, 4'b0000, 1'b1, 32'hDEAD_BEEF);
        checkCycle("read resp", 4'b0000, 4'b0100, 4'b0000);
        checkOutput("read rdata m2", 64'(rdata1[2]), 64'hDEAD_BEEF);
        applyStimulus(1'b0, 4'b0010, 1'b1, '0);
        checkCycle("write m1", 4'b0010, 4'b0000, 4'b0100);
        checkOutput("write slv_wen", 64'(swen1), 64'd0);
        checkOutput("write slv_wdata", 64'(swdata1), 64'h1234_5678);
        checkOutput("write slv_be", 64'(sbe1), 64'h3);
        applyStimulus(1'b0, 4'b0000, 1'b1, '0);
        checkCycle("write resp1", 4'b0000, 4'b0010, 4'b0000);
        applyStimulus(1'b0, 4'b0000, 1'b1, '0);
        checkCycle("write resp2", 4'b0000, 4'b0000, 4'b0010);

        applyStimulus(1'b0, 4'b0100, 1'b1, '0);
        checkCycle("wrap setup", 4'b0100, 4'b0000, 4'b0000);
        applyStimulus(1'b0, 4'b0101, 1'b1, '0);
        checkCycle("wrap m0", 4'b0001, 4'b0100, 4'b0000);
        applyStimulus(1'b0, 4'b0100, 1'b1, '0);
        checkCycle("wrap m2", 4'b0100, 4'b0001, 4'b0100);
        applyStimulus(1'b0, 4'b0000, 1'b1, '0);
        checkCycle("wrap drain1", 4'b0000, 4'b0100, 4'b0001);
        applyStimulus(1'b0, 4'b0000, 1'b1, '0);
        checkCycle("wrap drain2", 4'b0000, 4'b0000, 4'b0100);

        applyStimulus(1'b0, 4'b1110, 1'b1, '0);
        checkCycle("inflight A", 4'b1000, 4'b0000, 4'b0000);
        applyStimulus(1'b0, 4'b1110, 1'b1, '0);
        checkCycle("inflight B", 4'b0010, 4'b1000, 4'b0000);
        applyStimulus(1'b1, 4'b0000, 1'b1, '0);
        checkCycle("midreset", 4'b0000, 4'b0010, 4'b1000);
        applyStimulus(1'b0, 4'b0000, 1'b1, '0);
        checkCycle("post reset1", 4'b0000, 4'b0000, 4'b0000);
        applyStimulus(1'b0, 4'b0000, 1'b1, '0);
        checkCycle("post reset2", 4'b0000, 4'b0000, 4'b0000);
        applyStimulus(1'b0, 4'b1111, 1'b1, '0);
        checkCycle("ptr cleared", 4'b0001, 4'b0000, 4'b0000);
        applyStimulus(1'b0, 4'b0000, 1'b1, '0);
        checkCycle("ptr cleared resp", 4'b0000, 4'b0001, 4'b0000);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
